// File: rtl/time_setup_ctrl.sv
// Button-driven time-setting controller: freezes the time counters while the user
// edits hours/minutes/seconds in shadow registers, then loads all three in one strobe.
module time_setup_ctrl #(
    parameter int SEC_MAX      = 59,
    parameter int MIN_MAX      = 59,
    parameter int HOUR_MAX     = 23,
    parameter int BLINK_DIV    = 25000000,
    parameter int IDLE_TIMEOUT = 500000000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            btn_mode,
    input  logic                            btn_inc,
    input  logic                            btn_dec,
    input  logic                            btn_cancel,
    input  logic [$clog2(HOUR_MAX+1)-1:0]   cur_hour,
    input  logic [$clog2(MIN_MAX+1)-1:0]    cur_min,
    input  logic [$clog2(SEC_MAX+1)-1:0]    cur_sec,
    output logic                            run_en,
    output logic                            setup_imp,
    output logic [$clog2(HOUR_MAX+1)-1:0]   setup_hour,
    output logic [$clog2(MIN_MAX+1)-1:0]    setup_min,
    output logic [$clog2(SEC_MAX+1)-1:0]    setup_sec,
    output logic [1:0]                      edit_field,
    output logic                            blink
);

    localparam int HW = $clog2(HOUR_MAX + 1);
    localparam int MW = $clog2(MIN_MAX + 1);
    localparam int SW = $clog2(SEC_MAX + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_EDIT_H = 3'd1,
        ST_EDIT_M = 3'd2,
        ST_EDIT_S = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] sh_hour_q, sh_hour_d;
    logic [MW-1:0] sh_min_q, sh_min_d;
    logic [SW-1:0] sh_sec_q, sh_sec_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          run_en_q, run_en_d;
    logic          setup_imp_q, setup_imp_d;
    logic [HW-1:0] setup_hour_q, setup_hour_d;
    logic [MW-1:0] setup_min_q, setup_min_d;
    logic [SW-1:0] setup_sec_q, setup_sec_d;
    logic [1:0]    edit_field_q, edit_field_d;

    logic          btn_any_s;
    logic          abort_s;
    logic          step_s;
    logic          edit_next_s;

    // Wrapping +/-1 on a field bounded by max (fields are at most 8 bits wide).
    function automatic logic [7:0] field_step(input logic [7:0] v, input logic [7:0] max,
                                              input logic up);
        logic [7:0] r;
        if (up) begin
            r = (v == max) ? 8'd0 : v + 8'd1;
        end else begin
            r = (v == 8'd0) ? max : v - 8'd1;
        end
        return r;
    endfunction

    // Next-state, shadow edit, timers and registered output values.
    always_comb begin
        state_d      = state_q;
        sh_hour_d    = sh_hour_q;
        sh_min_d     = sh_min_q;
        sh_sec_d     = sh_sec_q;
        idle_d       = idle_q;
        blink_cnt_d  = blink_cnt_q;
        blink_d      = blink_q;
        setup_hour_d = setup_hour_q;
        setup_min_d  = setup_min_q;
        setup_sec_d  = setup_sec_q;
        edit_field_d = 2'd0;

        btn_any_s = btn_mode | btn_inc | btn_dec | btn_cancel;
        abort_s   = btn_cancel | (idle_q == IDLE_LAST);
        step_s    = btn_inc ^ btn_dec;

        case (state_q)
            ST_RUN: begin
                if (btn_mode) begin
                    state_d   = ST_EDIT_H;
                    sh_hour_d = cur_hour;
                    sh_min_d  = cur_min;
                    sh_sec_d  = cur_sec;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_EDIT_H: begin
                if (abort_s) begin
                    state_d = ST_RUN;
                end else if (btn_mode) begin
                    state_d = ST_EDIT_M;
                end else if (step_s) begin
                    sh_hour_d = HW'(field_step(8'(sh_hour_q), 8'(HOUR_MAX), btn_inc));
                end else begin
                    state_d = ST_EDIT_H;
                end
            end
            ST_EDIT_M: begin
                if (abort_s) begin
                    state_d = ST_RUN;
                end else if (btn_mode) begin
                    state_d = ST_EDIT_S;
                end else if (step_s) begin
                    sh_min_d = MW'(field_step(8'(sh_min_q), 8'(MIN_MAX), btn_inc));
                end else begin
                    state_d = ST_EDIT_M;
                end
            end
            ST_EDIT_S: begin
                if (abort_s) begin
                    state_d = ST_RUN;
                end else if (btn_mode) begin
                    state_d = ST_COMMIT;
                end else if (step_s) begin
                    sh_sec_d = SW'(field_step(8'(sh_sec_q), 8'(SEC_MAX), btn_inc));
                end else begin
                    state_d = ST_EDIT_S;
                end
            end
            ST_COMMIT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        edit_next_s = (state_d == ST_EDIT_H) || (state_d == ST_EDIT_M) || (state_d == ST_EDIT_S);

        // Entering edit or changing field restarts both the blink phase and its divider.
        if (edit_next_s) begin
            if (state_d != state_q) begin
                blink_cnt_d = {BW{1'b0}};
                blink_d     = 1'b0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = {BW{1'b0}};
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blink_d     = blink_q;
            end
            if ((state_q == ST_RUN) || btn_any_s) begin
                idle_d = {IW{1'b0}};
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end else begin
            blink_cnt_d = {BW{1'b0}};
            blink_d     = 1'b0;
            idle_d      = {IW{1'b0}};
        end

        run_en_d    = (state_d == ST_RUN);
        setup_imp_d = (state_d == ST_COMMIT);
        if (state_d == ST_COMMIT) begin
            setup_hour_d = sh_hour_q;
            setup_min_d  = sh_min_q;
            setup_sec_d  = sh_sec_q;
        end else begin
            setup_hour_d = setup_hour_q;
            setup_min_d  = setup_min_q;
            setup_sec_d  = setup_sec_q;
        end

        case (state_d)
            ST_EDIT_H: edit_field_d = 2'd1;
            ST_EDIT_M: edit_field_d = 2'd2;
            ST_EDIT_S: edit_field_d = 2'd3;
            default:   edit_field_d = 2'd0;
        endcase
    end

    // State, shadow, timer and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            sh_hour_q    <= {HW{1'b0}};
            sh_min_q     <= {MW{1'b0}};
            sh_sec_q     <= {SW{1'b0}};
            idle_q       <= {IW{1'b0}};
            blink_cnt_q  <= {BW{1'b0}};
            blink_q      <= 1'b0;
            run_en_q     <= 1'b1;
            setup_imp_q  <= 1'b0;
            setup_hour_q <= {HW{1'b0}};
            setup_min_q  <= {MW{1'b0}};
            setup_sec_q  <= {SW{1'b0}};
            edit_field_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            sh_hour_q    <= sh_hour_d;
            sh_min_q     <= sh_min_d;
            sh_sec_q     <= sh_sec_d;
            idle_q       <= idle_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            run_en_q     <= run_en_d;
            setup_imp_q  <= setup_imp_d;
            setup_hour_q <= setup_hour_d;
            setup_min_q  <= setup_min_d;
            setup_sec_q  <= setup_sec_d;
            edit_field_q <= edit_field_d;
        end
    end

    assign run_en     = run_en_q;
    assign setup_imp  = setup_imp_q;
    assign setup_hour = setup_hour_q;
    assign setup_min  = setup_min_q;
    assign setup_sec  = setup_sec_q;
    assign edit_field = edit_field_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_time_setup_ctrl.sv
// Directed table-driven bench for time_setup_ctrl, with short blink divider and idle timeout.
module tb_time_setup_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
    logic [4:0] cur_hour = 5'd0;
    logic [5:0] cur_min = 6'd0, cur_sec = 6'd0;
    logic       run_en, setup_imp, blink;
    logic [4:0] setup_hour;
    logic [5:0] setup_min, setup_sec;
    logic [1:0] edit_field;

    int n_vec = 0;
    int n_bad = 0;
    logic seen_imp = 1'b0;

    time_setup_ctrl #(
        .SEC_MAX(59), .MIN_MAX(59), .HOUR_MAX(23), .BLINK_DIV(4), .IDLE_TIMEOUT(100)
    ) dut (
        .clock(clock), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_cancel(btn_cancel),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .run_en(run_en), .setup_imp(setup_imp),
        .setup_hour(setup_hour), .setup_min(setup_min), .setup_sec(setup_sec),
        .edit_field(edit_field), .blink(blink)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] btn;   // {mode, inc, dec, cancel}
        logic [4:0] ch;
        logic [5:0] cm, cs;
        logic       er, ei;
        logic [4:0] eh;
        logic [5:0] em, es;
        logic [1:0] ef;
        logic       eb;
    } vec_t;

    vec_t vecs[$];

    localparam logic [3:0] N = 4'b0000, M = 4'b1000, I = 4'b0100, D = 4'b0010, C = 4'b0001;

    task automatic add(input logic [3:0] btn, input int ch, input int cm, input int cs,
                       input logic er, input logic ei, input int eh, input int em, input int es,
                       input int ef, input logic eb);
        vec_t v;
        v.btn = btn; v.ch = 5'(ch); v.cm = 6'(cm); v.cs = 6'(cs);
        v.er = er; v.ei = ei; v.eh = 5'(eh); v.em = 6'(em); v.es = 6'(es);
        v.ef = 2'(ef); v.eb = eb;
        vecs.push_back(v);
    endtask

    task automatic tick(input logic [3:0] btn, input logic [4:0] h, input logic [5:0] m,
                        input logic [5:0] s);
        @(negedge clock);
        {btn_mode, btn_inc, btn_dec, btn_cancel} = btn;
        cur_hour = h; cur_min = m; cur_sec = s;
        @(posedge clock);
        #1;
        if (setup_imp) seen_imp = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, run_en, setup_imp, setup_hour, setup_min, setup_sec, edit_field, blink};
    endfunction

    initial begin
        // 12:34:56 -> +3 hours, -1 minute, commit 15:33:56
        add(N, 12,34,56, 1,0,  0, 0, 0, 0,0);
        add(M, 12,34,56, 0,0,  0, 0, 0, 1,0);
        add(I, 12,34,56, 0,0,  0, 0, 0, 1,0);
        add(I, 12,34,56, 0,0,  0, 0, 0, 1,0);
        add(I, 12,34,56, 0,0,  0, 0, 0, 1,0);
        add(M, 12,34,56, 0,0,  0, 0, 0, 2,0);
        add(D, 12,34,56, 0,0,  0, 0, 0, 2,0);
        add(M, 12,34,56, 0,0,  0, 0, 0, 3,0);
        add(M, 12,34,56, 0,1, 15,33,56, 0,0);
        add(N, 12,34,56, 1,0, 15,33,56, 0,0);
        add(N, 12,34,56, 1,0, 15,33,56, 0,0);
        // 23:00:00: hour wrap, blink pattern 0,0,0,0,1,1,1,1,0
        add(M, 23, 0, 0, 0,0, 15,33,56, 1,0);
        add(I, 23, 0, 0, 0,0, 15,33,56, 1,0);
        add(N, 23, 0, 0, 0,0, 15,33,56, 1,0);
        add(N, 23, 0, 0, 0,0, 15,33,56, 1,0);
        add(N, 23, 0, 0, 0,0, 15,33,56, 1,1);
        add(N, 23, 0, 0, 0,0, 15,33,56, 1,1);
        add(N, 23, 0, 0, 0,0, 15,33,56, 1,1);
        add(N, 23, 0, 0, 0,0, 15,33,56, 1,1);
        add(N, 23, 0, 0, 0,0, 15,33,56, 1,0);
        // field change restarts blink; minute/second dec wrap; inc+dec is a no-op
        add(M, 23, 0, 0, 0,0, 15,33,56, 2,0);
        add(D, 23, 0, 0, 0,0, 15,33,56, 2,0);
        add(I|D, 23, 0, 0, 0,0, 15,33,56, 2,0);
        add(M, 23, 0, 0, 0,0, 15,33,56, 3,0);
        add(D, 23, 0, 0, 0,0, 15,33,56, 3,0);
        add(N, 23, 0, 0, 0,0, 15,33,56, 3,0);
        add(M, 23, 0, 0, 0,1,  0,59,59, 0,0);
        add(N, 23, 0, 0, 1,0,  0,59,59, 0,0);
        // mode+cancel leaves edit with no load
        add(M,  1, 2, 3, 0,0,  0,59,59, 1,0);
        add(M,  1, 2, 3, 0,0,  0,59,59, 2,0);
        add(M|C, 1, 2, 3, 1,0, 0,59,59, 0,0);
        // 23:59:59: increment wraps on every field
        add(M, 23,59,59, 0,0,  0,59,59, 1,0);
        add(I, 23,59,59, 0,0,  0,59,59, 1,0);
        add(M, 23,59,59, 0,0,  0,59,59, 2,0);
        add(I, 23,59,59, 0,0,  0,59,59, 2,0);
        add(M, 23,59,59, 0,0,  0,59,59, 3,0);
        add(I, 23,59,59, 0,0,  0,59,59, 3,0);
        add(M, 23,59,59, 0,1,  0, 0, 0, 0,0);
        add(N, 23,59,59, 1,0,  0, 0, 0, 0,0);
        // cancel from the minute field
        add(M,  0,10,20, 0,0,  0, 0, 0, 1,0);
        add(D,  0,10,20, 0,0,  0, 0, 0, 1,0);
        add(M,  0,10,20, 0,0,  0, 0, 0, 2,0);
        add(C,  0,10,20, 1,0,  0, 0, 0, 0,0);

        reset = 1'b1;
        tick(N, 5'd0, 6'd0, 6'd0);
        tick(N, 5'd0, 6'd0, 6'd0);
        check("reset", outs(), {10'd0, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0, 2'd0, 1'b0});
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].btn, vecs[i].ch, vecs[i].cm, vecs[i].cs);
            check($sformatf("vec%0d", i), outs(),
                  {10'd0, vecs[i].er, vecs[i].ei, vecs[i].eh, vecs[i].em, vecs[i].es,
                   vecs[i].ef, vecs[i].eb});
        end

        // idle timeout: abandon after 100 button-free edit cycles
        seen_imp = 1'b0;
        tick(M, 5'd5, 6'd6, 6'd7);
        for (int k = 0; k < 99; k++) tick(N, 5'd5, 6'd6, 6'd7);
        check("idle_still_edit", {30'd0, run_en, edit_field != 2'd0}, {30'd0, 1'b0, 1'b1});
        tick(N, 5'd5, 6'd6, 6'd7);
        check("idle_timeout", {29'd0, run_en, edit_field}, {29'd0, 1'b1, 2'd0});
        check("idle_noload", {14'd0, seen_imp, setup_hour, setup_min, setup_sec},
              {14'd0, 1'b0, 5'd0, 6'd0, 6'd0});

        // give setup_* a nonzero value so the mid-edit reset is observable
        tick(M, 5'd9, 6'd8, 6'd7);
        tick(M, 5'd9, 6'd8, 6'd7);
        tick(M, 5'd9, 6'd8, 6'd7);
        tick(M, 5'd9, 6'd8, 6'd7);
        check("commit_987", outs(), {10'd0, 1'b0, 1'b1, 5'd9, 6'd8, 6'd7, 2'd0, 1'b0});
        tick(N, 5'd9, 6'd8, 6'd7);

        // reset in EDIT_S: back to RUN with no load
        seen_imp = 1'b0;
        tick(M, 5'd1, 6'd2, 6'd3);
        tick(M, 5'd1, 6'd2, 6'd3);
        tick(M, 5'd1, 6'd2, 6'd3);
        check("in_edit_s", {30'd0, edit_field}, {30'd0, 2'd3});
        reset = 1'b1;
        tick(N, 5'd1, 6'd2, 6'd3);
        reset = 1'b0;
        check("reset_mid_edit", outs(), {10'd0, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0, 2'd0, 1'b0});
        for (int k = 0; k < 4; k++) tick(N, 5'd1, 6'd2, 6'd3);
        check("reset_noload", {30'd0, seen_imp, run_en}, {30'd0, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
